mdu_seq: RTL

Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core. It sits in the E stage beside the ALU and owns the architectural HI/LO registers. It executes mult/multu/div/divu with configurable latency and raises `busy` so hazard logic can stall dependent instructions. mthi/mtlo/mfhi/mflo are handled here too, giving the control unit one uniform target for every HI/LO instruction.

---
 rtl/mdu_seq_if.sv | 23 ++
 rtl/mdu_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mdu_seq_if.sv
// Handshake and result bundle between the E-stage control and the multiply/divide unit.
interface mdu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             md_stall;

    modport master (
        output start, op, a, b,
        input  busy, hi, lo, md_stall
    );

    modport slave (
        input  start, op, a, b,
        output busy, hi, lo, md_stall
    );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit owning HI/LO; results commit after a fixed busy window.
// Optional madd/maddu accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_seq #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic      clk,
    input logic      reset_n,
    mdu_seq_if.slave md
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;
    localparam logic [2:0] OpMadd  = 3'd6;
    localparam logic [2:0] OpMaddu = 3'd7;

    typedef enum logic {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic               pend_we_q, pend_we_d;

    logic               signed_mul;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;
    logic               is_arith;

    // Sign/zero extension to 2*WIDTH makes one truncated product serve both signednesses.
    always_comb begin
        signed_mul = (md.op == OpMult) || (md.op == OpMadd);
        a_ext = signed_mul ? {{WIDTH{md.a[WIDTH-1]}}, md.a} : {{WIDTH{1'b0}}, md.a};
        b_ext = signed_mul ? {{WIDTH{md.b[WIDTH-1]}}, md.b} : {{WIDTH{1'b0}}, md.b};
        prod  = a_ext * b_ext;
    end

    // Signed divide via magnitudes: most-negative / -1 falls out as most-negative, remainder 0.
    always_comb begin
        a_neg   = (md.op == OpDiv) && md.a[WIDTH-1];
        b_neg   = (md.op == OpDiv) && md.b[WIDTH-1];
        a_mag   = a_neg ? -md.a : md.a;
        b_mag   = b_neg ? -md.b : md.b;
        divisor = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem     = a_neg ? -r_mag : r_mag;
    end

    always_comb begin
        is_arith = (md.op == OpMult) || (md.op == OpMultu) ||
                   (md.op == OpDiv)  || (md.op == OpDivu);
`ifdef MDU_MADD_EN
        is_arith = is_arith || (md.op == OpMadd) || (md.op == OpMaddu);
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;

        case (state_q)
            StIdle: begin
                if (md.start) begin
                    case (md.op)
                        OpMult, OpMultu: begin
                            {pend_hi_d, pend_lo_d} = prod;
                            pend_we_d = 1'b1;
                            cnt_d     = MultCnt;
                            state_d   = StRun;
                        end
                        OpDiv, OpDivu: begin
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                            pend_we_d = (md.b != '0);
                            cnt_d     = DivCnt;
                            state_d   = StRun;
                        end
                        OpMthi: hi_d = md.a;
                        OpMtlo: lo_d = md.a;
`ifdef MDU_MADD_EN
                        OpMadd, OpMaddu: begin
                            {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod;
                            pend_we_d = 1'b1;
                            cnt_d     = MultCnt;
                            state_d   = StRun;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StIdle;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign md.busy     = (state_q == StRun);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.md_stall = md.busy | (md.start & is_arith);
endmodule
